// File: rtl/flash_burst_arbiter.sv
// Round-robin arbiter for N Avalon-MM clients in front of the flash data port.
// Routes registered read beats back to the granted client; aborts stalled bursts on timeout.
module flash_burst_arbiter #(
  parameter int N_CLIENTS   = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]   cl_addr,
  input  logic [N_CLIENTS-1:0]              cl_read,
  input  logic [N_CLIENTS-1:0]              cl_write,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]   cl_writedata,
  input  logic [N_CLIENTS*BURST_WIDTH-1:0]  cl_burstcount,
  output logic [N_CLIENTS-1:0]              cl_waitrequest,
  output logic [DATA_WIDTH-1:0]             cl_readdata,
  output logic [N_CLIENTS-1:0]              cl_readdatavalid,
  output logic [ADDR_WIDTH-1:0]             avmm_data_addr,
  output logic                              avmm_data_read,
  output logic                              avmm_data_write,
  output logic [DATA_WIDTH-1:0]             avmm_data_writedata,
  output logic [BURST_WIDTH-1:0]            avmm_data_burstcount,
  input  logic                              avmm_data_waitrequest,
  input  logic [DATA_WIDTH-1:0]             avmm_data_readdata,
  input  logic                              avmm_data_readdatavalid,
  output logic                              err_timeout,
  output logic                              err_unsolicited,
  input  logic                              err_clear
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          rr, grant, sel;
  logic [N_CLIENTS-1:0]   req;
  logic                   any_req;
  logic                   accept;
  logic                   last_beat;
  logic                   timed_out;
  logic [BURST_WIDTH-1:0] beats;
  logic [TW-1:0]          timer;

  assign req       = cl_read | cl_write;
  assign accept    = (state == CMD) && !avmm_data_waitrequest;
  assign last_beat = avmm_data_readdatavalid && (beats == BURST_WIDTH'(1));
  assign timed_out = (state == DATA) && !avmm_data_readdatavalid && (timer == TW'(TIMEOUT));

  // Search starts one past the last served client so it drops to lowest priority.
  always_comb begin
    int idx;
    idx     = 0;
    sel     = '0;
    any_req = 1'b0;
    for (int i = 1; i <= N_CLIENTS; i++) begin
      idx = (int'(rr) + i) % N_CLIENTS;
      if (!any_req && req[IW'(idx)]) begin
        any_req = 1'b1;
        sel     = IW'(idx);
      end
    end
  end

  always_comb begin
    cl_waitrequest = '1;
    if (accept) cl_waitrequest[grant] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = CMD;
      CMD:  if (accept) state_nxt = avmm_data_read ? DATA : IDLE;
      DATA: if (last_beat || timed_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr                   <= '0;
      grant                <= '0;
      beats                <= '0;
      timer                <= '0;
      avmm_data_addr       <= '0;
      avmm_data_read       <= 1'b0;
      avmm_data_write      <= 1'b0;
      avmm_data_writedata  <= '0;
      avmm_data_burstcount <= '0;
      cl_readdata          <= '0;
      cl_readdatavalid     <= '0;
      err_timeout          <= 1'b0;
      err_unsolicited      <= 1'b0;
    end else begin
      cl_readdatavalid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant               <= sel;
            avmm_data_addr      <= cl_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            avmm_data_writedata <= cl_writedata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            avmm_data_read      <= cl_read[sel];
            avmm_data_write     <= !cl_read[sel] && cl_write[sel];
            avmm_data_burstcount <= cl_read[sel] ?
                                    cl_burstcount[int'(sel)*BURST_WIDTH +: BURST_WIDTH] :
                                    BURST_WIDTH'(1);
          end
        end
        CMD: begin
          if (accept) begin
            avmm_data_read  <= 1'b0;
            avmm_data_write <= 1'b0;
            rr              <= grant;
            timer           <= '0;
            if (avmm_data_read)
              beats <= (avmm_data_burstcount == '0) ? BURST_WIDTH'(1) : avmm_data_burstcount;
          end
        end
        DATA: begin
          if (avmm_data_readdatavalid) begin
            cl_readdata      <= avmm_data_readdata;
            cl_readdatavalid <= N_CLIENTS'(1) << grant;
            beats            <= beats - BURST_WIDTH'(1);
            timer            <= '0;
          end else if (!timed_out) begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase

      // Clear takes precedence so software never loses a clear to a same-cycle event.
      if (err_clear)      err_timeout <= 1'b0;
      else if (timed_out) err_timeout <= 1'b1;

      if (err_clear)
        err_unsolicited <= 1'b0;
      else if (avmm_data_readdatavalid && (state != DATA))
        err_unsolicited <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flash_burst_arbiter.sv
// Directed bench for flash_burst_arbiter: two clients, TIMEOUT=4, hand-computed expectations.
module tb_flash_burst_arbiter;

  logic        clock;
  logic        reset_n;
  logic [31:0] cl_addr;
  logic [1:0]  cl_read;
  logic [1:0]  cl_write;
  logic [63:0] cl_writedata;
  logic [3:0]  cl_burstcount;
  logic [1:0]  cl_waitrequest;
  logic [31:0] cl_readdata;
  logic [1:0]  cl_readdatavalid;
  logic [15:0] avmm_data_addr;
  logic        avmm_data_read;
  logic        avmm_data_write;
  logic [31:0] avmm_data_writedata;
  logic [1:0]  avmm_data_burstcount;
  logic        avmm_data_waitrequest;
  logic [31:0] avmm_data_readdata;
  logic        avmm_data_readdatavalid;
  logic        err_timeout;
  logic        err_unsolicited;
  logic        err_clear;

  int n_cmp = 0;
  int n_bad = 0;

  flash_burst_arbiter #(
    .N_CLIENTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .BURST_WIDTH(2), .TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cl_addr(cl_addr),
    .cl_read(cl_read),
    .cl_write(cl_write),
    .cl_writedata(cl_writedata),
    .cl_burstcount(cl_burstcount),
    .cl_waitrequest(cl_waitrequest),
    .cl_readdata(cl_readdata),
    .cl_readdatavalid(cl_readdatavalid),
    .avmm_data_addr(avmm_data_addr),
    .avmm_data_read(avmm_data_read),
    .avmm_data_write(avmm_data_write),
    .avmm_data_writedata(avmm_data_writedata),
    .avmm_data_burstcount(avmm_data_burstcount),
    .avmm_data_waitrequest(avmm_data_waitrequest),
    .avmm_data_readdata(avmm_data_readdata),
    .avmm_data_readdatavalid(avmm_data_readdatavalid),
    .err_timeout(err_timeout),
    .err_unsolicited(err_unsolicited),
    .err_clear(err_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_addr;
    logic [1:0]  exp_wreq;

    reset_n = 1'b0;
    cl_addr = '0; cl_read = '0; cl_write = '0; cl_writedata = '0; cl_burstcount = '0;
    avmm_data_waitrequest = 1'b1; avmm_data_readdata = '0; avmm_data_readdatavalid = 1'b0;
    err_clear = 1'b0;

    // reset values
    @(negedge clock); @(negedge clock);
    chk("rst_read", avmm_data_read, 0);
    chk("rst_write", avmm_data_write, 0);
    chk("rst_addr", avmm_data_addr, 0);
    chk("rst_bc", avmm_data_burstcount, 0);
    chk("rst_wreq", cl_waitrequest, 2'b11);
    chk("rst_rdv", cl_readdatavalid, 0);
    chk("rst_rdata", cl_readdata, 0);
    chk("rst_errs", {err_timeout, err_unsolicited}, 0);
    reset_n = 1'b1;

    // 1: single read, client0, two flash wait cycles
    cl_addr[15:0] = 16'h0123; cl_burstcount[1:0] = 2'd1; cl_read[0] = 1'b1;
    step;
    chk("t1_read", avmm_data_read, 1);
    chk("t1_addr", avmm_data_addr, 16'h0123);
    chk("t1_bc", avmm_data_burstcount, 1);
    chk("t1_wreq_stall1", cl_waitrequest, 2'b11);
    step;
    chk("t1_read_held", avmm_data_read, 1);
    chk("t1_wreq_stall2", cl_waitrequest, 2'b11);
    avmm_data_waitrequest = 1'b0;
    #1 chk("t1_wreq_accept", cl_waitrequest, 2'b10);
    step;
    cl_read = '0; avmm_data_waitrequest = 1'b1;
    #1 chk("t1_wreq_after", cl_waitrequest, 2'b11);
    chk("t1_read_drop", avmm_data_read, 0);
    chk("t1_rdv_early", cl_readdatavalid, 0);
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'hDEADBEEF;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t1_rdv", cl_readdatavalid, 2'b01);
    chk("t1_rdata", cl_readdata, 32'hDEADBEEF);
    step;
    chk("t1_rdv_pulse", cl_readdatavalid, 0);

    // 2: both clients write continuously; rr=0 so client1 is searched first
    avmm_data_waitrequest = 1'b0;
    cl_addr = {16'h0200, 16'h0100}; cl_write = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 16'h0200 : 16'h0100;
      exp_wreq = (k % 2 == 0) ? 2'b01 : 2'b10;
      step;
      chk("t2_write", avmm_data_write, 1);
      chk("t2_grant_addr", avmm_data_addr, exp_addr);
      chk("t2_wreq", cl_waitrequest, exp_wreq);
      step;
      if (k == 3) cl_write = '0;
      chk("t2_write_drop", avmm_data_write, 0);
      chk("t2_wreq_idle", cl_waitrequest, 2'b11);
    end

    // 3: burst-2 read on client1, beats separated by 3 idle cycles
    cl_addr[31:16] = 16'h0040; cl_burstcount[3:2] = 2'd2; cl_read[1] = 1'b1;
    step;
    chk("t3_read", avmm_data_read, 1);
    chk("t3_addr", avmm_data_addr, 16'h0040);
    chk("t3_bc", avmm_data_burstcount, 2);
    chk("t3_wreq", cl_waitrequest, 2'b01);
    step;
    cl_read = '0;
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'h11111111;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t3_rdv1", cl_readdatavalid, 2'b10);
    chk("t3_rdata1", cl_readdata, 32'h11111111);
    for (int g = 0; g < 3; g++) begin
      step;
      chk("t3_gap", cl_readdatavalid, 0);
    end
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'h22222222;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t3_rdv2", cl_readdatavalid, 2'b10);
    chk("t3_rdata2", cl_readdata, 32'h22222222);
    chk("t3_no_timeout", err_timeout, 0);

    // 4: back in IDLE, so a new request issues immediately; only 1 of 2 beats arrives
    cl_addr[15:0] = 16'h0080; cl_burstcount[1:0] = 2'd2; cl_read[0] = 1'b1;
    step;
    chk("t4_read", avmm_data_read, 1);
    chk("t4_addr", avmm_data_addr, 16'h0080);
    chk("t4_wreq", cl_waitrequest, 2'b10);
    step;
    cl_read = '0;
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'h33333333;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t4_rdv", cl_readdatavalid, 2'b01);
    for (int w = 1; w <= 4; w++) begin
      step;
      chk("t4_to_pending", err_timeout, 0);
    end
    step;
    chk("t4_timeout", err_timeout, 1);
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'h44444444;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t4_unsolicited", err_unsolicited, 1);
    chk("t4_late_rdv", cl_readdatavalid, 0);
    chk("t4_late_rdata", cl_readdata, 32'h33333333);
    err_clear = 1'b1;
    step;
    err_clear = 1'b0;
    chk("t4_clear", {err_timeout, err_unsolicited}, 0);

    // 5: write with burstcount 2 is sent as burst 1 and held through waitrequest
    avmm_data_waitrequest = 1'b1;
    cl_addr[15:0] = 16'h0010; cl_writedata[31:0] = 32'h5A5A5A5A; cl_burstcount[1:0] = 2'd2;
    cl_write[0] = 1'b1;
    step;
    chk("t5_write", avmm_data_write, 1);
    chk("t5_read", avmm_data_read, 0);
    chk("t5_bc", avmm_data_burstcount, 1);
    chk("t5_addr", avmm_data_addr, 16'h0010);
    chk("t5_wdata", avmm_data_writedata, 32'h5A5A5A5A);
    chk("t5_wreq_stall", cl_waitrequest, 2'b11);
    step;
    chk("t5_write_held", avmm_data_write, 1);
    chk("t5_bc_held", avmm_data_burstcount, 1);
    avmm_data_waitrequest = 1'b0;
    #1 chk("t5_wreq_accept", cl_waitrequest, 2'b10);
    step;
    cl_write = '0;
    chk("t5_write_drop", avmm_data_write, 0);

    // 6: asynchronous reset in the middle of a burst, then a clean read
    cl_addr[15:0] = 16'h0200; cl_burstcount[1:0] = 2'd2; cl_read[0] = 1'b1;
    step;
    chk("t6_read", avmm_data_read, 1);
    step;
    cl_read = '0;
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'h55555555;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t6_rdv", cl_readdatavalid, 2'b01);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_rdv", cl_readdatavalid, 0);
    chk("t6_rst_rdata", cl_readdata, 0);
    chk("t6_rst_addr", avmm_data_addr, 0);
    chk("t6_rst_wreq", cl_waitrequest, 2'b11);
    step;
    reset_n = 1'b1;
    cl_addr[31:16] = 16'h0300; cl_burstcount[3:2] = 2'd1; cl_read[1] = 1'b1;
    step;
    chk("t6_new_read", avmm_data_read, 1);
    chk("t6_new_addr", avmm_data_addr, 16'h0300);
    chk("t6_new_wreq", cl_waitrequest, 2'b01);
    step;
    cl_read = '0;
    avmm_data_readdatavalid = 1'b1; avmm_data_readdata = 32'hCAFEF00D;
    step;
    avmm_data_readdatavalid = 1'b0;
    chk("t6_new_rdv", cl_readdatavalid, 2'b10);
    chk("t6_new_rdata", cl_readdata, 32'hCAFEF00D);
    chk("t6_errs", {err_timeout, err_unsolicited}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
